// File: rtl/miriscv_alu_pkg.sv
// Shared ALU definitions: operator encoding and opcode legality check.
// Used by the ALU itself and by the arbiter that shares it between requesters.
package miriscv_alu_pkg;

   localparam int ALU_OP_WIDTH = 4;

   typedef enum logic [ALU_OP_WIDTH-1:0] {
      ALU_ADD = 4'h0,
      ALU_SUB = 4'h1,
      ALU_XOR = 4'h2,
      ALU_OR  = 4'h3,
      ALU_AND = 4'h4,
      ALU_SRA = 4'h5,
      ALU_SRL = 4'h6,
      ALU_SLL = 4'h7,
      ALU_LTS = 4'h8,
      ALU_LTU = 4'h9,
      ALU_GES = 4'hA,
      ALU_GEU = 4'hB,
      ALU_EQ  = 4'hC,
      ALU_NE  = 4'hD
   } alu_op_e;

   // Codes above NE are unassigned and must not reach a response register.
   function automatic logic alu_op_legal(input logic [ALU_OP_WIDTH-1:0] op);
      return op <= ALU_NE;
   endfunction

endpackage

// File: rtl/miriscv_alu.sv
// Purely combinational 32-bit ALU; zero latency, no flow control.
// Comparison ops report the outcome on flag and as a zero-extended result.
module miriscv_alu
   import miriscv_alu_pkg::*;
(
   input  alu_op_e     alu_op_i,
   input  logic [31:0] alu_a_i,
   input  logic [31:0] alu_b_i,
   output logic [31:0] alu_result_o,
   output logic        alu_flag_o
);

   always_comb begin
      alu_flag_o = 1'b0;
      case (alu_op_i)
         ALU_LTS: alu_flag_o = $signed(alu_a_i) <  $signed(alu_b_i);
         ALU_LTU: alu_flag_o = alu_a_i <  alu_b_i;
         ALU_GES: alu_flag_o = $signed(alu_a_i) >= $signed(alu_b_i);
         ALU_GEU: alu_flag_o = alu_a_i >= alu_b_i;
         ALU_EQ:  alu_flag_o = alu_a_i == alu_b_i;
         ALU_NE:  alu_flag_o = alu_a_i != alu_b_i;
         default: alu_flag_o = 1'b0;
      endcase
   end

   always_comb begin
      alu_result_o = 32'd0;
      case (alu_op_i)
         ALU_ADD: alu_result_o = alu_a_i + alu_b_i;
         ALU_SUB: alu_result_o = alu_a_i - alu_b_i;
         ALU_XOR: alu_result_o = alu_a_i ^ alu_b_i;
         ALU_OR:  alu_result_o = alu_a_i | alu_b_i;
         ALU_AND: alu_result_o = alu_a_i & alu_b_i;
         ALU_SRA: alu_result_o = $unsigned($signed(alu_a_i) >>> alu_b_i[4:0]);
         ALU_SRL: alu_result_o = alu_a_i >> alu_b_i[4:0];
         ALU_SLL: alu_result_o = alu_a_i << alu_b_i[4:0];
         ALU_LTS, ALU_LTU, ALU_GES, ALU_GEU, ALU_EQ, ALU_NE:
            alu_result_o = {31'd0, alu_flag_o};
         default: alu_result_o = 32'd0;
      endcase
   end

endmodule

// File: rtl/miriscv_alu_arbiter.sv
// Round-robin share of one ALU between two requesters; result registered, visible the cycle after the handshake.
// A requester is stalled while its response slot is full and not being drained; the other may take every cycle.
module miriscv_alu_arbiter
   import miriscv_alu_pkg::*;
#(
   parameter logic RR_RESET = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,

   input  logic                    req0_valid_i,
   output logic                    req0_ready_o,
   input  logic [ALU_OP_WIDTH-1:0] req0_op_i,
   input  logic [31:0]             req0_a_i,
   input  logic [31:0]             req0_b_i,

   input  logic                    req1_valid_i,
   output logic                    req1_ready_o,
   input  logic [ALU_OP_WIDTH-1:0] req1_op_i,
   input  logic [31:0]             req1_a_i,
   input  logic [31:0]             req1_b_i,

   output logic                    rsp0_valid_o,
   input  logic                    rsp0_ready_i,
   output logic [31:0]             rsp0_result_o,
   output logic                    rsp0_flag_o,

   output logic                    rsp1_valid_o,
   input  logic                    rsp1_ready_i,
   output logic [31:0]             rsp1_result_o,
   output logic                    rsp1_flag_o,

   output logic                    last_grant_o
);

   logic                    prio;
   logic                    elig0, elig1;
   logic                    grant0, grant1;
   logic [ALU_OP_WIDTH-1:0] alu_op;
   logic [31:0]             alu_a, alu_b;
   logic [31:0]             alu_result;
   logic                    alu_flag;
   logic                    op_legal;
   logic [31:0]             cap_result;
   logic                    cap_flag;

   // Reset gates eligibility so ready stays low while the block is held in reset.
   assign elig0  = req0_valid_i & (~rsp0_valid_o | rsp0_ready_i) & ~rst_i;
   assign elig1  = req1_valid_i & (~rsp1_valid_o | rsp1_ready_i) & ~rst_i;
   assign grant0 = elig0 & (~elig1 | ~prio);
   assign grant1 = elig1 & (~elig0 |  prio);

   assign req0_ready_o = grant0;
   assign req1_ready_o = grant1;

   assign alu_op = grant1 ? req1_op_i : req0_op_i;
   assign alu_a  = grant1 ? req1_a_i  : req0_a_i;
   assign alu_b  = grant1 ? req1_b_i  : req0_b_i;

   miriscv_alu u_alu (
      .alu_op_i     (alu_op_e'(alu_op)),
      .alu_a_i      (alu_a),
      .alu_b_i      (alu_b),
      .alu_result_o (alu_result),
      .alu_flag_o   (alu_flag)
   );

   assign op_legal   = alu_op_legal(alu_op);
   assign cap_result = op_legal ? alu_result : 32'd0;
   assign cap_flag   = op_legal & alu_flag;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prio          <= RR_RESET;
         last_grant_o  <= RR_RESET;
         rsp0_valid_o  <= 1'b0;
         rsp0_result_o <= 32'd0;
         rsp0_flag_o   <= 1'b0;
         rsp1_valid_o  <= 1'b0;
         rsp1_result_o <= 32'd0;
         rsp1_flag_o   <= 1'b0;
      end else begin
         if (grant0 | grant1) begin
            prio         <= grant0;
            last_grant_o <= grant1;
         end

         if (grant0) begin
            rsp0_valid_o  <= 1'b1;
            rsp0_result_o <= cap_result;
            rsp0_flag_o   <= cap_flag;
         end else if (rsp0_ready_i) begin
            rsp0_valid_o  <= 1'b0;
         end

         if (grant1) begin
            rsp1_valid_o  <= 1'b1;
            rsp1_result_o <= cap_result;
            rsp1_flag_o   <= cap_flag;
         end else if (rsp1_ready_i) begin
            rsp1_valid_o  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_miriscv_alu_arbiter.sv
// Directed bench for the shared-ALU arbiter: reset, single op, contention,
// backpressure, illegal opcodes, shift/compare ops and asynchronous reset.
module tb_miriscv_alu_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req0_valid_i, req1_valid_i;
   logic        req0_ready_o, req1_ready_o;
   logic [3:0]  req0_op_i, req1_op_i;
   logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
   logic        rsp0_valid_o, rsp1_valid_o;
   logic        rsp0_ready_i, rsp1_ready_i;
   logic [31:0] rsp0_result_o, rsp1_result_o;
   logic        rsp0_flag_o, rsp1_flag_o;
   logic        last_grant_o;

   int n_checks = 0;
   int n_pass   = 0;

   miriscv_alu_arbiter #(.RR_RESET(1'b0)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req0_valid_i  (req0_valid_i),
      .req0_ready_o  (req0_ready_o),
      .req0_op_i     (req0_op_i),
      .req0_a_i      (req0_a_i),
      .req0_b_i      (req0_b_i),
      .req1_valid_i  (req1_valid_i),
      .req1_ready_o  (req1_ready_o),
      .req1_op_i     (req1_op_i),
      .req1_a_i      (req1_a_i),
      .req1_b_i      (req1_b_i),
      .rsp0_valid_o  (rsp0_valid_o),
      .rsp0_ready_i  (rsp0_ready_i),
      .rsp0_result_o (rsp0_result_o),
      .rsp0_flag_o   (rsp0_flag_o),
      .rsp1_valid_o  (rsp1_valid_o),
      .rsp1_ready_i  (rsp1_ready_i),
      .rsp1_result_o (rsp1_result_o),
      .rsp1_flag_o   (rsp1_flag_o),
      .last_grant_o  (last_grant_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_inputs();
      req0_valid_i = 0; req0_op_i = 0; req0_a_i = 0; req0_b_i = 0;
      req1_valid_i = 0; req1_op_i = 0; req1_a_i = 0; req1_b_i = 0;
      rsp0_ready_i = 0; rsp1_ready_i = 0;
   endtask

   task automatic apply_reset();
      rst_i = 1;
      #3;
      rst_i = 0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_i = 1;
      #12;
      rst_i = 0;
      #1;
      n_checks++; if (rsp0_valid_o !== 1'b0) $display("FAIL reset_rsp0_valid: got %b want 0", rsp0_valid_o); else n_pass++;
      n_checks++; if (rsp1_valid_o !== 1'b0) $display("FAIL reset_rsp1_valid: got %b want 0", rsp1_valid_o); else n_pass++;
      n_checks++; if (rsp0_result_o !== 32'd0 || rsp0_flag_o !== 1'b0) $display("FAIL reset_rsp0_data: got %h/%b want 0/0", rsp0_result_o, rsp0_flag_o); else n_pass++;
      n_checks++; if (rsp1_result_o !== 32'd0 || rsp1_flag_o !== 1'b0) $display("FAIL reset_rsp1_data: got %h/%b want 0/0", rsp1_result_o, rsp1_flag_o); else n_pass++;
      n_checks++; if (last_grant_o !== 1'b0) $display("FAIL reset_last_grant: got %b want 0", last_grant_o); else n_pass++;
      n_checks++; if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) $display("FAIL reset_ready: got %b%b want 00", req0_ready_o, req1_ready_o); else n_pass++;
      @(posedge clk_i); #1;
   endtask

   task automatic test_single();
      req0_valid_i = 1; req0_op_i = 4'h0; req0_a_i = 32'd5; req0_b_i = 32'd7;
      rsp0_ready_i = 0;
      @(negedge clk_i);
      n_checks++; if (req0_ready_o !== 1'b1) $display("FAIL single_req0_ready: got %b want 1", req0_ready_o); else n_pass++;
      n_checks++; if (req1_ready_o !== 1'b0) $display("FAIL single_req1_ready: got %b want 0", req1_ready_o); else n_pass++;
      @(posedge clk_i); #1;
      req0_valid_i = 0;
      n_checks++; if (rsp0_valid_o !== 1'b1) $display("FAIL single_rsp_valid: got %b want 1", rsp0_valid_o); else n_pass++;
      n_checks++; if (rsp0_result_o !== 32'd12 || rsp0_flag_o !== 1'b0) $display("FAIL single_rsp_data: got %h/%b want 0000000c/0", rsp0_result_o, rsp0_flag_o); else n_pass++;
      n_checks++; if (last_grant_o !== 1'b0) $display("FAIL single_last_grant: got %b want 0", last_grant_o); else n_pass++;
      @(posedge clk_i); #1;
      n_checks++; if (rsp0_valid_o !== 1'b1 || rsp0_result_o !== 32'd12) $display("FAIL single_hold: got %b/%h want 1/0000000c", rsp0_valid_o, rsp0_result_o); else n_pass++;
      rsp0_ready_i = 1;
      @(posedge clk_i); #1;
      n_checks++; if (rsp0_valid_o !== 1'b0) $display("FAIL single_drain: got %b want 0", rsp0_valid_o); else n_pass++;
      rsp0_ready_i = 0;
   endtask

   task automatic test_contention();
      apply_reset();
      rsp0_ready_i = 1; rsp1_ready_i = 1;
      req0_valid_i = 1; req0_op_i = 4'h1; req0_a_i = 32'd3;          req0_b_i = 32'd5;
      req1_valid_i = 1; req1_op_i = 4'h8; req1_a_i = 32'hFFFF_FFFF; req1_b_i = 32'd1;
      for (int i = 0; i < 4; i++) begin
         logic exp_g;
         exp_g = i[0];
         @(negedge clk_i);
         n_checks++; if (req0_ready_o !== ~exp_g || req1_ready_o !== exp_g) $display("FAIL contention_ready[%0d]: got %b%b want %b%b", i, req0_ready_o, req1_ready_o, ~exp_g, exp_g); else n_pass++;
         @(posedge clk_i); #1;
         n_checks++; if (last_grant_o !== exp_g) $display("FAIL contention_grant[%0d]: got %b want %b", i, last_grant_o, exp_g); else n_pass++;
         if (exp_g == 1'b0) begin
            n_checks++; if (rsp0_valid_o !== 1'b1 || rsp0_result_o !== 32'hFFFF_FFFE || rsp0_flag_o !== 1'b0 || rsp1_valid_o !== 1'b0)
               $display("FAIL contention_rsp0[%0d]: got v%b %h f%b other_v%b want v1 fffffffe f0 other_v0", i, rsp0_valid_o, rsp0_result_o, rsp0_flag_o, rsp1_valid_o); else n_pass++;
         end else begin
            n_checks++; if (rsp1_valid_o !== 1'b1 || rsp1_result_o !== 32'd1 || rsp1_flag_o !== 1'b1 || rsp0_valid_o !== 1'b0)
               $display("FAIL contention_rsp1[%0d]: got v%b %h f%b other_v%b want v1 00000001 f1 other_v0", i, rsp1_valid_o, rsp1_result_o, rsp1_flag_o, rsp0_valid_o); else n_pass++;
         end
      end
      req0_valid_i = 0; req1_valid_i = 0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_backpressure();
      rsp0_ready_i = 0; rsp1_ready_i = 1;
      req0_valid_i = 1; req0_op_i = 4'h0; req0_a_i = 32'd1; req0_b_i = 32'd2;
      @(negedge clk_i);
      n_checks++; if (req0_ready_o !== 1'b1) $display("FAIL bp_first_ready: got %b want 1", req0_ready_o); else n_pass++;
      @(posedge clk_i); #1;
      n_checks++; if (rsp0_valid_o !== 1'b1 || rsp0_result_o !== 32'd3) $display("FAIL bp_first_rsp: got %b/%h want 1/00000003", rsp0_valid_o, rsp0_result_o); else n_pass++;
      req0_op_i = 4'h1; req0_a_i = 32'd50; req0_b_i = 32'd8;
      req1_valid_i = 1; req1_op_i = 4'h0; req1_b_i = 32'd100;
      for (int i = 0; i < 3; i++) begin
         req1_a_i = 32'(i * 16);
         @(negedge clk_i);
         n_checks++; if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b1) $display("FAIL bp_stall_ready[%0d]: got %b%b want 01", i, req0_ready_o, req1_ready_o); else n_pass++;
         @(posedge clk_i); #1;
         n_checks++; if (rsp1_result_o !== 32'(i * 16 + 100) || last_grant_o !== 1'b1) $display("FAIL bp_req1[%0d]: got %h g%b want %h g1", i, rsp1_result_o, last_grant_o, 32'(i * 16 + 100)); else n_pass++;
         n_checks++; if (rsp0_valid_o !== 1'b1 || rsp0_result_o !== 32'd3) $display("FAIL bp_rsp0_hold[%0d]: got %b/%h want 1/00000003", i, rsp0_valid_o, rsp0_result_o); else n_pass++;
      end
      rsp0_ready_i = 1;
      @(negedge clk_i);
      n_checks++; if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) $display("FAIL bp_release_ready: got %b%b want 10", req0_ready_o, req1_ready_o); else n_pass++;
      @(posedge clk_i); #1;
      n_checks++; if (rsp0_valid_o !== 1'b1 || rsp0_result_o !== 32'd42 || last_grant_o !== 1'b0) $display("FAIL bp_overwrite: got v%b %h g%b want v1 0000002a g0", rsp0_valid_o, rsp0_result_o, last_grant_o); else n_pass++;
      req0_valid_i = 0; req1_valid_i = 0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_illegal();
      rsp1_ready_i = 1;
      req1_valid_i = 1; req1_a_i = 32'hFFFF_FFFF; req1_b_i = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         req1_op_i = (i == 0) ? 4'hE : 4'hF;
         @(negedge clk_i);
         n_checks++; if (req1_ready_o !== 1'b1) $display("FAIL illegal_ready[%0d]: got %b want 1", i, req1_ready_o); else n_pass++;
         @(posedge clk_i); #1;
         n_checks++; if (rsp1_valid_o !== 1'b1 || rsp1_result_o !== 32'd0 || rsp1_flag_o !== 1'b0) $display("FAIL illegal_rsp[%0d]: got v%b %h f%b want v1 00000000 f0", i, rsp1_valid_o, rsp1_result_o, rsp1_flag_o); else n_pass++;
      end
      req1_valid_i = 0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_ops();
      logic [3:0]  t_op  [6] = '{4'h5, 4'hD, 4'hC, 4'h7, 4'h9, 4'h6};
      logic [31:0] t_a   [6] = '{32'h8000_0000, 32'd9, 32'd9, 32'd1, 32'd1, 32'h8000_0000};
      logic [31:0] t_b   [6] = '{32'd4, 32'd9, 32'd9, 32'd31, 32'hFFFF_FFFF, 32'd4};
      logic [31:0] t_res [6] = '{32'hF800_0000, 32'd0, 32'd1, 32'h8000_0000, 32'd1, 32'h0800_0000};
      logic        t_flg [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      rsp0_ready_i = 1;
      req0_valid_i = 1;
      for (int i = 0; i < 6; i++) begin
         req0_op_i = t_op[i]; req0_a_i = t_a[i]; req0_b_i = t_b[i];
         @(negedge clk_i);
         n_checks++; if (req0_ready_o !== 1'b1) $display("FAIL ops_ready[%0d]: got %b want 1", i, req0_ready_o); else n_pass++;
         @(posedge clk_i); #1;
         n_checks++; if (rsp0_valid_o !== 1'b1 || rsp0_result_o !== t_res[i] || rsp0_flag_o !== t_flg[i])
            $display("FAIL ops_rsp[%0d]: got v%b %h f%b want v1 %h f%b", i, rsp0_valid_o, rsp0_result_o, rsp0_flag_o, t_res[i], t_flg[i]); else n_pass++;
      end
      req0_valid_i = 0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_async_reset();
      rsp0_ready_i = 0; rsp1_ready_i = 0;
      req0_valid_i = 1; req0_op_i = 4'h0; req0_a_i = 32'd1; req0_b_i = 32'd1;
      @(posedge clk_i); #1;
      req0_valid_i = 0;
      req1_valid_i = 1; req1_op_i = 4'h0; req1_a_i = 32'd2; req1_b_i = 32'd2;
      @(posedge clk_i); #1;
      n_checks++; if (rsp0_valid_o !== 1'b1 || rsp1_valid_o !== 1'b1 || last_grant_o !== 1'b1) $display("FAIL areset_fill: got v%b%b g%b want v11 g1", rsp0_valid_o, rsp1_valid_o, last_grant_o); else n_pass++;
      req0_valid_i = 1;
      #2;
      rst_i = 1;
      #1;
      n_checks++; if (rsp0_valid_o !== 1'b0 || rsp1_valid_o !== 1'b0) $display("FAIL areset_valid: got %b%b want 00", rsp0_valid_o, rsp1_valid_o); else n_pass++;
      n_checks++; if (rsp0_result_o !== 32'd0 || rsp1_result_o !== 32'd0) $display("FAIL areset_result: got %h/%h want 0/0", rsp0_result_o, rsp1_result_o); else n_pass++;
      n_checks++; if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) $display("FAIL areset_ready: got %b%b want 00", req0_ready_o, req1_ready_o); else n_pass++;
      req0_valid_i = 0; req1_valid_i = 0;
      #1;
      rst_i = 0;
      #1;
      n_checks++; if (last_grant_o !== 1'b0) $display("FAIL areset_last_grant: got %b want 0", last_grant_o); else n_pass++;
      @(posedge clk_i); #1;
      n_checks++; if (rsp0_valid_o !== 1'b0 || rsp1_valid_o !== 1'b0) $display("FAIL areset_after: got %b%b want 00", rsp0_valid_o, rsp1_valid_o); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_illegal();
      test_ops();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/miriscv_alu_arbiter.md
# miriscv_alu_arbiter

Shares the single combinational 32-bit ALU between two requesters (e.g. the core execute stage and a debug/CSR path) with independent valid/ready request and response channels. A round-robin arbiter grants at most one operation per cycle. The granted operation is evaluated through the shared ALU and its result and flag are captured into a per-requester response register. The block sits between the requesters and the one ALU instance, so the ALU is never driven by two sources.

## Interface
- `RR_RESET`, default 0: requester holding priority after reset (0 or 1).
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `reqN_valid_i`  in  1  requester N (N=0,1) presents an operation.
- `reqN_ready_o`  out  1  operation of requester N accepted this cycle.
- `reqN_op_i`  in  4  ALU operator code (ADD..NE, 0x0–0xD).
- `reqN_a_i`, `reqN_b_i`  in  32  operands.
- `rspN_valid_o`  out  1  response register N holds a result.
- `rspN_ready_i`  in  1  requester N consumes the response.
- `rspN_result_o`  out  32  registered ALU result.
- `rspN_flag_o`  out  1  registered ALU comparison flag.
- `last_grant_o`  out  1  index of the most recently granted requester.

## Operation
- **Eligibility.** Requester N is eligible when `reqN_valid_i` is high and response slot N is free or draining: `!rspN_valid_o || rspN_ready_i`.
- **Arbitration.** One-bit priority pointer `prio`.
  - Both eligible: grant `prio`.
  - One eligible: grant it.
  - After any grant: `prio <= ~granted`; `last_grant_o <= granted`.
  - No grant: `prio` and `last_grant_o` are unchanged.
- **Ready.** `reqN_ready_o` is high only when requester N is granted. It is combinational from valid, response state and `prio`. It must never depend on operand values.
- **ALU drive.** The granted requester's op/a/b are muxed onto the ALU. When there is no grant, the ALU is driven with requester 0's payload and its output is discarded.
- **Capture.** On a grant, the ALU result and flag are written into slot N and `rspN_valid_o <= 1`.
- **Slot clear.** `rspN_valid_o <= 0` when `rspN_ready_i` is high and there is no new grant to N in the same cycle. A drain and a new grant to N in the same cycle overwrite the slot and keep valid at 1.
- **Illegal opcodes.** Op 0xE/0xF are accepted normally but return result 0 and flag 0. They are masked in this block, not forwarded to the ALU output.
- **Requester obligation.** While `valid && !ready`, op/a/b must stay stable. The block does not check this.
- **Reset.**
  - Outputs: `rspN_valid_o=0`, `rspN_result_o=0`, `rspN_flag_o=0`, `reqN_ready_o=0`, `last_grant_o=RR_RESET`.
  - Internal state: `prio=RR_RESET`.
  - Reset mid-operation discards held responses; no partial state survives.

## Timing
- **Latency.** Handshake at edge N makes the response visible in cycle N+1: `rspN_valid_o` is high and result/flag are stable.
- **Throughput.**
  - Aggregate: one operation per cycle.
  - Per requester: one per cycle while its `rspN_ready_i` stays high.
  - With sustained contention: alternating grants, 1/2 rate each.
- **Backpressure.** If `rspN_ready_i` is low and slot N is full, requester N is ineligible. The other requester may take every cycle meanwhile.
- **Stability.** Response outputs are held constant while `rspN_valid_o && !rspN_ready_i`.
- **Timing paths.** No combinational path from `rspN_ready_i` to `rspN_valid_o`. A combinational path from `rspN_ready_i` to `reqN_ready_o` is permitted.

## Structure
- **Shared package `miriscv_alu_pkg`:**
  - `ALU_OP_WIDTH`.
  - All 14 operator codes (replacing the current `define` list).
  - Function `alu_op_legal(op)`.
- **Sub-module.** Exactly one instance of the existing `miriscv_alu`. Arbitration, muxing and response registers are inline; no further sub-module.
- **File size.** Expected RTL about 150–220 lines.

## Test plan
- **Reset.** Assert `rst_i` asynchronously mid-cycle with both slots full. Required: all valids/results go 0 immediately; `last_grant_o=RR_RESET` after release.
- **Single request.** req0 ADD a=5, b=7. Required: `req0_ready_o=1` same cycle; next cycle `rsp0_valid_o=1`, result=12, flag=0.
- **Contention.** Both valid every cycle with `rsp*_ready_i=1`, `RR_RESET=0`:
  - req0 SUB a=3, b=5 gets result 0xFFFFFFFE.
  - req1 LTS a=0xFFFFFFFF, b=1 gets result 1, flag 1.
  - Required: grants alternate 0,1,0,1.
- **Backpressure.**
  - Hold `rsp0_ready_i=0` after one req0 response. Required: `req0_ready_o` stays 0 and req1 is granted every cycle.
  - Release `rsp0_ready_i`. Required: req0 is granted in that same cycle; the slot is overwritten and valid stays 1.
- **Illegal opcode.** req1 op 0xE, a=b=0xFFFFFFFF. Required: accepted; response result 0, flag 0.
- **Shift and compare ops.** SRA a=0x80000000, b=4 gives 0xF8000000. NE a=b=9 gives result 0, flag 0.
